// File: rtl/boot_pkg.sv
// Shared definitions for the byte-stream boot loader: section header codes
// and the loader state encoding.
package boot_pkg;

  localparam logic [7:0] HDR_IMEM = 8'h01;
  localparam logic [7:0] HDR_DMEM = 8'h02;
  localparam logic [7:0] HDR_END  = 8'hFF;

  typedef enum logic [2:0] {
    HDR,
    LEN_HI,
    LEN_LO,
    DATA,
    DONE,
    ERR
  } state_e;

  typedef enum logic {
    TGT_IMEM,
    TGT_DMEM
  } target_e;

endpackage

// File: rtl/boot_word_packer.sv
// Assembles four stream bytes (MSB first) into a 32-bit word; word_done
// fires combinationally alongside the 4th byte so the caller can register it.
module boot_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        shift_en,
  input  logic        clear,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] asm_q, asm_d;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    if (clear) begin
      byte_cnt_d = '0;
      asm_d      = '0;
    end else if (shift_en) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      asm_d      = {asm_q[15:0], in_byte};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt_q <= '0;
      asm_q      <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
    end
  end

  // Only the first three bytes are stored; the 4th is taken straight from the input.
  assign word      = {asm_q, in_byte};
  assign word_done = shift_en && !clear && (byte_cnt_q == 2'd3);

endmodule

// File: rtl/mem_boot_loader.sv
// Parses header/length/data sections from a byte stream, writes the words
// into instruction or data memory, and releases cpu_reset once the end marker arrives.
module mem_boot_loader
  import boot_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam logic [16:0] IMEM_DEPTH = 17'(IMEM_WORDS);
  localparam logic [16:0] DMEM_DEPTH = 17'(DMEM_WORDS);

  state_e            state_q, state_d;
  target_e           target_q, target_d;
  logic [15:0]       count_q, count_d;
  logic [15:0]       word_idx_q, word_idx_d;
  logic              imem_we_q, imem_we_d, dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d, dmem_addr_q, dmem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d, dmem_wdata_q, dmem_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;

  logic        accept;
  logic        word_done;
  logic [31:0] word;
  logic [15:0] len_full;
  logic [16:0] depth;

  assign in_ready = (state_q == HDR) || (state_q == LEN_HI) ||
                    (state_q == LEN_LO) || (state_q == DATA);
  assign accept   = in_valid && in_ready;
  assign len_full = {count_q[15:8], in_data};
  assign depth    = (target_q == TGT_DMEM) ? DMEM_DEPTH : IMEM_DEPTH;

  boot_word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (accept && (state_q == DATA)),
    .clear     (state_q != DATA),
    .in_byte   (in_data),
    .word      (word),
    .word_done (word_done)
  );

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    count_d      = count_q;
    word_idx_d   = word_idx_q;
    imem_we_d    = 1'b0;
    dmem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    case (state_q)
      HDR: if (accept) begin
        if (in_data == HDR_IMEM) begin
          target_d = TGT_IMEM;
          state_d  = LEN_HI;
        end else if (in_data == HDR_DMEM) begin
          target_d = TGT_DMEM;
          state_d  = LEN_HI;
        end else if (in_data == HDR_END) begin
          state_d = DONE;
        end else begin
          state_d = ERR;
        end
      end
      LEN_HI: if (accept) begin
        count_d = {in_data, 8'h00};
        state_d = LEN_LO;
      end
      LEN_LO: if (accept) begin
        count_d = len_full;
        if (len_full == 16'd0) begin
          state_d = HDR;
        end else if ({1'b0, len_full} > depth) begin
          state_d = ERR;
        end else begin
          word_idx_d = '0;
          state_d    = DATA;
        end
      end
      DATA: if (word_done) begin
        if (target_q == TGT_DMEM) begin
          dmem_we_d    = 1'b1;
          dmem_addr_d  = word_idx_q[ADDR_W-1:0];
          dmem_wdata_d = word;
        end else begin
          imem_we_d    = 1'b1;
          imem_addr_d  = word_idx_q[ADDR_W-1:0];
          imem_wdata_d = word;
        end
        word_idx_d = word_idx_q + 16'd1;
        if (word_idx_q == count_q - 16'd1) state_d = HDR;
      end
      default: ;
    endcase
    // Registered so the processor leaves reset on the first cycle spent in DONE.
    cpu_reset_d = (state_d != DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= HDR;
      target_q     <= TGT_IMEM;
      count_q      <= '0;
      word_idx_q   <= '0;
      imem_we_q    <= 1'b0;
      dmem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      count_q      <= count_d;
      word_idx_q   <= word_idx_d;
      imem_we_q    <= imem_we_d;
      dmem_we_q    <= dmem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = (state_q == DONE);
  assign error      = (state_q == ERR);

endmodule

// File: tb/tb_mem_boot_loader.sv
// Directed bench for mem_boot_loader: table of byte streams with expected
// memory writes, plus hand sequences for timing, full-depth and gapped streams.
module tb_mem_boot_loader;

  localparam logic [9:0] RST_C  = 10'h100;
  localparam logic [9:0] IDLE_C = 10'h200;
  localparam int NS = 80;
  localparam int NV = 7;
  localparam int NW = 9;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, imem_we, dmem_we, cpu_reset, done, error;
  logic [7:0]  imem_addr, dmem_addr;
  logic [31:0] imem_wdata, dmem_wdata;

  mem_boot_loader #(.IMEM_WORDS(256), .DMEM_WORDS(256), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] start;
    logic [15:0] len;
    logic [15:0] wstart;
    logic [15:0] nw;
    logic        exp_done;
    logic        exp_err;
    logic [15:0] acc;
  } vec_t;

  logic [9:0]  stim  [NS];
  logic [40:0] exp_w [NW];
  vec_t        vecs  [NV];

  int n_checks = 0;
  int n_fail   = 0;
  int acc_cnt  = 0;
  int both_we  = 0;
  logic [40:0] wq[$];

  // Writes captured as {is_dmem, addr, data}; accepted bytes counted on the falling edge.
  always @(negedge clk) begin
    if (in_valid && in_ready) acc_cnt++;
    if (imem_we && dmem_we) both_we++;
    if (imem_we) wq.push_back({1'b0, imem_addr, imem_wdata});
    if (dmem_we) wq.push_back({1'b1, dmem_addr, dmem_wdata});
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end else begin
      $display("ok   %s: 0x%0h", nm, act);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    reset = 1'b1;
    idle();
  endtask

  function automatic logic [31:0] dw(input int i);
    return 32'h9E3779B9 * 32'(i + 1);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim = '{
      10'h001, 10'h000, 10'h002, 10'h000, 10'h000, 10'h000, 10'h007, 10'h000, 10'h000, 10'h001, 10'h000, 10'h0FF,
      10'h002, 10'h000, 10'h003, 10'h000, 10'h000, 10'h001, 10'h000, 10'h000, 10'h000, 10'h002, 10'h000,
      10'h000, 10'h000, 10'h001, 10'h050, 10'h001, 10'h000, 10'h000, 10'h0FF,
      10'h005, 10'h001, 10'h000, 10'h001, 10'h0FF,
      10'h001, 10'h001, 10'h001, 10'h000, 10'h000, 10'h000, 10'h000,
      10'h002, 10'h000, 10'h001, 10'h0AA, 10'h0BB, 10'h100, 10'h002, 10'h000, 10'h001, 10'h012, 10'h034,
      10'h056, 10'h078, 10'h0FF,
      10'h002, 10'h000, 10'h001, 10'h0AA, 10'h0AA, 10'h0AA, 10'h0AA, 10'h001, 10'h000, 10'h001, 10'h011,
      10'h022, 10'h033, 10'h044, 10'h002, 10'h000, 10'h001, 10'h055, 10'h066, 10'h077, 10'h088, 10'h0FF,
      10'h000
    };
    exp_w = '{
      {1'b0, 8'd0, 32'h0000_0007}, {1'b0, 8'd1, 32'h0000_0100},
      {1'b1, 8'd0, 32'h0000_0100}, {1'b1, 8'd1, 32'h0000_0200}, {1'b1, 8'd2, 32'h0000_0150},
      {1'b1, 8'd0, 32'h1234_5678},
      {1'b1, 8'd0, 32'hAAAA_AAAA}, {1'b0, 8'd0, 32'h1122_3344}, {1'b1, 8'd0, 32'h5566_7788}
    };
    vecs = '{
      '{16'd0,  16'd12, 16'd0, 16'd2, 1'b1, 1'b0, 16'd12},
      '{16'd12, 16'd19, 16'd2, 16'd3, 1'b1, 1'b0, 16'd19},
      '{16'd31, 16'd5,  16'd5, 16'd0, 1'b0, 1'b1, 16'd1},
      '{16'd36, 16'd7,  16'd5, 16'd0, 1'b0, 1'b1, 16'd3},
      '{16'd43, 16'd14, 16'd5, 16'd1, 1'b1, 1'b0, 16'd13},
      '{16'd57, 16'd22, 16'd6, 16'd3, 1'b1, 1'b0, 16'd22},
      '{16'd79, 16'd1,  16'd9, 16'd0, 1'b0, 1'b1, 16'd1}
    };

    do_reset();
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_error", 64'(error), 64'd0);
    chk("reset_we", 64'({imem_we, dmem_we}), 64'd0);

    for (int v = 0; v < NV; v++) begin
      do_reset();
      wq.delete();
      acc_cnt = 0;
      both_we = 0;
      chk($sformatf("v%0d_start_in_ready", v), 64'(in_ready), 64'd1);
      chk($sformatf("v%0d_start_cpu_reset", v), 64'(cpu_reset), 64'd1);
      for (int i = 0; i < int'(vecs[v].len); i++) begin
        logic [9:0] code;
        code = stim[int'(vecs[v].start) + i];
        if (code == RST_C) begin
          reset = 1'b0;
          #1;
          reset = 1'b1;
        end else if (code == IDLE_C) begin
          idle();
        end else begin
          send(code[7:0]);
        end
      end
      idle();
      idle();
      chk($sformatf("v%0d_write_count", v), 64'(wq.size()), 64'(vecs[v].nw));
      for (int k = 0; k < int'(vecs[v].nw); k++) begin
        if (k < wq.size())
          chk($sformatf("v%0d_write%0d", v, k), 64'(wq[k]), 64'(exp_w[int'(vecs[v].wstart) + k]));
      end
      chk($sformatf("v%0d_done", v), 64'(done), 64'(vecs[v].exp_done));
      chk($sformatf("v%0d_error", v), 64'(error), 64'(vecs[v].exp_err));
      chk($sformatf("v%0d_cpu_reset", v), 64'(cpu_reset), 64'(!vecs[v].exp_done));
      chk($sformatf("v%0d_in_ready", v), 64'(in_ready), 64'(!(vecs[v].exp_done || vecs[v].exp_err)));
      chk($sformatf("v%0d_accepted", v), 64'(acc_cnt), 64'(vecs[v].acc));
      chk($sformatf("v%0d_single_we", v), 64'(both_we), 64'd0);
    end

    // Reset must clear the registered write-port outputs left over from the last load.
    do_reset();
    chk("rst_clear_imem", 64'({imem_addr, imem_wdata}), 64'd0);
    chk("rst_clear_dmem", 64'({dmem_addr, dmem_wdata}), 64'd0);

    // Cycle-exact strobe and cpu_reset timing.
    do_reset();
    send(8'h01); send(8'h00); send(8'h02); send(8'h00); send(8'h00); send(8'h00);
    chk("t1_we_before_4th", 64'(imem_we), 64'd0);
    send(8'h07);
    chk("t1_we_after_4th", 64'(imem_we), 64'd1);
    chk("t1_addr0", 64'(imem_addr), 64'd0);
    chk("t1_data0", 64'(imem_wdata), 64'h7);
    send(8'h00);
    chk("t1_we_one_cycle", 64'(imem_we), 64'd0);
    chk("t1_data_hold", 64'(imem_wdata), 64'h7);
    send(8'h00); send(8'h01); send(8'h00);
    chk("t1_addr1", 64'(imem_addr), 64'd1);
    chk("t1_data1", 64'(imem_wdata), 64'h100);
    chk("t1_cpu_reset_before_end", 64'(cpu_reset), 64'd1);
    send(8'hFF);
    chk("t1_cpu_reset_after_end", 64'(cpu_reset), 64'd0);
    chk("t1_done_after_end", 64'(done), 64'd1);
    chk("t1_in_ready_after_end", 64'(in_ready), 64'd0);

    // Full-depth data section: N = 256 must be accepted and reach address 255.
    do_reset();
    wq.delete();
    send(8'h02); send(8'h01); send(8'h00);
    for (int i = 0; i < 256; i++) begin
      logic [31:0] w;
      w = dw(i);
      send(w[31:24]); send(w[23:16]); send(w[15:8]); send(w[7:0]);
    end
    idle();
    chk("full_write_count", 64'(wq.size()), 64'd256);
    for (int i = 0; i < 256 && i < wq.size(); i++) begin
      if (wq[i] !== {1'b1, 8'(i), dw(i)})
        chk($sformatf("full_word%0d", i), 64'(wq[i]), 64'({1'b1, 8'(i), dw(i)}));
    end
    chk("full_last", 64'(wq.size() == 256 ? wq[255] : 41'd0), 64'({1'b1, 8'd255, dw(255)}));
    chk("full_error", 64'(error), 64'd0);
    send(8'hFF);
    chk("full_done", 64'(done), 64'd1);

    // Gapped stream must produce exactly the continuous-stream writes.
    do_reset();
    wq.delete();
    acc_cnt = 0;
    begin
      logic [7:0] gs [12];
      gs = '{8'h01, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h0B, 8'hAD, 8'hF0, 8'h0D, 8'hFF};
      for (int i = 0; i < 12; i++) begin
        repeat ($urandom_range(0, 2)) idle();
        send(gs[i]);
      end
    end
    idle();
    chk("gap_write_count", 64'(wq.size()), 64'd2);
    if (wq.size() == 2) begin
      chk("gap_write0", 64'(wq[0]), 64'({1'b0, 8'd0, 32'hDEADBEEF}));
      chk("gap_write1", 64'(wq[1]), 64'({1'b0, 8'd1, 32'h0BADF00D}));
    end
    chk("gap_accepted", 64'(acc_cnt), 64'd12);
    chk("gap_done", 64'(done), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_boot_loader.md
Name: mem_boot_loader

Overview:
- Synthesizable boot loader that fills instruction memory and data memory from a byte stream, then releases the processor from reset.
- Replaces the simulation-only hex-file preload: it is the writer into the two memories that the processor later reads.
- Sits between an external byte source (UART receiver or a bench driver) and the write ports of the instruction and data memories.
- Holds the processor reset asserted until the load completes.

Parameters:
IMEM_WORDS, 256, instruction memory depth in 32-bit words
DMEM_WORDS, 256, data memory depth in 32-bit words
ADDR_W, 8, word-address width on both memory write ports; must satisfy 2^ADDR_W >= max(IMEM_WORDS, DMEM_WORDS)

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  byte available on in_data
in_data  input  8  stream byte
in_ready  output  1  loader accepts the byte; a transfer occurs when in_valid and in_ready are both 1 on a rising edge
imem_we  output  1  one-cycle instruction memory write strobe
imem_addr  output  ADDR_W  instruction memory word address
imem_wdata  output  32  instruction word
dmem_we  output  1  one-cycle data memory write strobe
dmem_addr  output  ADDR_W  data memory word address
dmem_wdata  output  32  data word
cpu_reset  output  1  active-high reset to the processor
done  output  1  load finished
error  output  1  protocol error latched

Behaviour:
- Reset (reset=0, asynchronous): state=HDR, all counters 0, in_ready=1, imem_we=dmem_we=0, all addr/wdata outputs 0, cpu_reset=1, done=0, error=0. Any partially received word is discarded. Words already written stay in memory.
- Stream format, repeated per section:
  - header byte: 0x01 = instruction section, 0x02 = data section, 0xFF = end.
  - 16-bit word count N, high byte first.
  - N words of 4 bytes each, most-significant byte first.
  - Each section writes word addresses 0..N-1 of its target memory.
- States:
  - HDR: on accept of 0x01/0x02, latch target and go to LEN_HI. On 0xFF go to DONE. On any other byte go to ERR.
  - LEN_HI: latch the count high byte, go to LEN_LO.
  - LEN_LO: latch the count low byte.
    - N=0: go to HDR.
    - N greater than the target depth: go to ERR.
    - Otherwise: word_idx=0, byte_cnt=0, go to DATA.
  - DATA: on each accept, shift the byte into the 32-bit assembly register and increment byte_cnt mod 4.
    - On the 4th byte, load the target wdata output with the assembled word and the target addr output with word_idx; assert that target's we for exactly the next cycle.
    - Increment word_idx. If word_idx reaches N-1 on that write, go to HDR.
  - DONE: in_ready=0, done=1. cpu_reset goes 0 on the first cycle in DONE (registered: one cycle after the 0xFF handshake). Remain in DONE until reset.
  - ERR: in_ready=0, error=1, cpu_reset stays 1. Remain in ERR until reset.
- Latency and throughput:
  - The write strobe appears one cycle after the 4th byte handshake.
  - in_ready stays 1 in HDR/LEN/DATA, so back-to-back bytes are accepted every cycle with no stall.
  - The write strobe may overlap acceptance of the next header byte.
- Only one we is asserted at a time. addr/wdata outputs hold their last value while we=0.
- in_valid=0 in any state means no change; byte_cnt and word_idx hold.
- Sections may repeat or reorder, e.g. data then instruction, or the same target twice. A later section overwrites from address 0.
- N equal to the depth is legal and writes the last address, depth-1. N = depth+1 → ERR.

Decomposition:
- Shared package boot_pkg: header constants HDR_IMEM=0x01, HDR_DMEM=0x02, HDR_END=0xFF; state encoding HDR, LEN_HI, LEN_LO, DATA, DONE, ERR.
- One sub-module, boot_word_packer: 8-to-32 shift assembler with byte counter. Inputs: clk, reset, shift_en, clear. Outputs: word, word_done pulse.
- The FSM, address counter and write-port registers stay in mem_boot_loader.

Test Plan:
1. Send 01 00 02 | 00000007 00000100 | FF → imem_we pulses twice: addr0=0x00000007, then addr1=0x00000100. cpu_reset falls one cycle after the FF handshake; done=1.
2. Send 02 00 03 with words 0x100, 0x200, 0x150, then 01 00 00, then FF, all bytes back-to-back → dmem addr0..2 = 0x100, 0x200, 0x150. No imem_we. in_ready never drops before DONE.
3. Header byte 0x05 → error=1, in_ready=0, cpu_reset stays 1. Further bytes are ignored.
4. Send 01 01 01, i.e. N=257 with IMEM_WORDS=256 → ERR right after the LEN_LO byte; no write strobes.
5. Send 02 00 01 AA BB, then reset=0 for 1 ns, then 02 00 01 12 34 56 78 FF → the partial word is discarded. dmem addr0=0x12345678 and no other dmem writes. done=1.
6. Randomly toggle in_valid inside a 2-word imem load → written words and addresses are identical to the continuous-stream case.
